// File: rtl/fadd_arbiter_if.sv
// Request, adder and response signals of fadd_arbiter, grouped for port reuse.
// The slave modport is the arbiter side; master is the requester/adder/consumer side.
interface fadd_arbiter_if;
  logic        req0_valid;
  logic [15:0] req0_a;
  logic [15:0] req0_b;
  logic        req0_ready;
  logic        req1_valid;
  logic [15:0] req1_a;
  logic [15:0] req1_b;
  logic        req1_ready;
  logic [15:0] add_a;
  logic [15:0] add_b;
  logic [15:0] add_sum;
  logic        resp_valid;
  logic        resp_ready;
  logic [15:0] resp_data;
  logic        resp_id;
  logic        busy;

  modport slave (
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  add_sum, resp_ready,
    output req0_ready, req1_ready, add_a, add_b,
    output resp_valid, resp_data, resp_id, busy
  );

  modport master (
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output add_sum, resp_ready,
    input  req0_ready, req1_ready, add_a, add_b,
    input  resp_valid, resp_data, resp_id, busy
  );
endinterface

// File: rtl/fadd_arbiter.sv
// Round-robin arbiter sharing one combinational FP16 adder between two requesters.
// The adder is a LAT-cycle multicycle path: operands are held until the sum is captured.
module fadd_arbiter #(
  parameter int unsigned LAT = 2
) (
  input  logic           clk,
  input  logic           rst,
  fadd_arbiter_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [3:0]  r_cnt;
  logic        r_ptr;
  logic        r_id;
  logic [15:0] r_add_a;
  logic [15:0] r_add_b;
  logic [15:0] r_resp_data;

  logic        w_grant_vld;
  logic        w_grant;
  logic        w_accept;

  // Ready is masked during reset so a held request is never seen as accepted.
  always_comb begin
    w_grant_vld = bus.req0_valid | bus.req1_valid;
    w_grant     = (bus.req0_valid & bus.req1_valid) ? r_ptr : bus.req1_valid;
    w_accept    = (r_state == IDLE) & w_grant_vld & ~rst;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_accept) w_state_nxt = WAIT;
      WAIT:    if (r_cnt == '0) w_state_nxt = RESP;
      RESP:    if (bus.resp_ready) w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_cnt       <= '0;
      r_ptr       <= 1'b0;
      r_id        <= 1'b0;
      r_add_a     <= '0;
      r_add_b     <= '0;
      r_resp_data <= '0;
    end else begin
      if (w_accept) begin
        r_add_a <= w_grant ? bus.req1_a : bus.req0_a;
        r_add_b <= w_grant ? bus.req1_b : bus.req0_b;
        r_id    <= w_grant;
        r_ptr   <= ~w_grant;
        r_cnt   <= 4'(LAT - 1);
      end
      if (r_state == WAIT) begin
        if (r_cnt == '0) r_resp_data <= bus.add_sum;
        else             r_cnt       <= r_cnt - 4'd1;
      end
    end
  end

  assign bus.req0_ready = w_accept & ~w_grant;
  assign bus.req1_ready = w_accept & w_grant;
  assign bus.add_a      = r_add_a;
  assign bus.add_b      = r_add_b;
  assign bus.resp_valid = (r_state == RESP);
  assign bus.resp_data  = r_resp_data;
  assign bus.resp_id    = r_id;
  assign bus.busy       = (r_state != IDLE);

endmodule

// File: tb/tb_fadd_arbiter.sv
// Scoreboard bench for fadd_arbiter: three instances (LAT=2,1,15) with an integer-add adder stub.
// Expected {id,sum} is pushed at each accept and popped at each response handshake.
module tb_fadd_arbiter;

  logic clk = 1'b0;
  logic rst_a, rst_b, rst_c;
  int   n_vec = 0;
  int   n_err = 0;
  int   cyc   = 0;

  logic [16:0] q_a[$];
  logic [16:0] q_b[$];
  logic [16:0] q_c[$];
  logic        g_win[$];
  int          g_cyc[$];

  fadd_arbiter_if ia ();
  fadd_arbiter_if ib ();
  fadd_arbiter_if ic ();

  assign ia.add_sum = ia.add_a + ia.add_b;
  assign ib.add_sum = ib.add_a + ib.add_b;
  assign ic.add_sum = ic.add_a + ic.add_b;

  fadd_arbiter #(.LAT(2))  u_a (.clk(clk), .rst(rst_a), .bus(ia));
  fadd_arbiter #(.LAT(1))  u_b (.clk(clk), .rst(rst_b), .bus(ib));
  fadd_arbiter #(.LAT(15)) u_c (.clk(clk), .rst(rst_c), .bus(ic));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  function automatic int qsz(input int k);
    case (k)
      0:       return q_a.size();
      1:       return q_b.size();
      default: return q_c.size();
    endcase
  endfunction

  task automatic push(input int k, input logic [16:0] e);
    case (k)
      0:       q_a.push_back(e);
      1:       q_b.push_back(e);
      default: q_c.push_back(e);
    endcase
  endtask

  task automatic pop(input int k, output logic [16:0] e);
    case (k)
      0:       e = q_a.pop_front();
      1:       e = q_b.pop_front();
      default: e = q_c.pop_front();
    endcase
  endtask

  task automatic mon(input int k, input logic r,
                     input logic v0, input logic r0, input logic [15:0] a0, input logic [15:0] b0,
                     input logic v1, input logic r1, input logic [15:0] a1, input logic [15:0] b1,
                     input logic rv, input logic rr, input logic [15:0] rd, input logic rid);
    logic [16:0] e;
    if (r) begin
      case (k)
        0:       q_a.delete();
        1:       q_b.delete();
        default: q_c.delete();
      endcase
    end else begin
      if (rv && rr) begin
        chk("sb_nonempty", qsz(k) != 0, 1);
        if (qsz(k) != 0) begin
          pop(k, e);
          chk("resp_data", rd, e[15:0]);
          chk("resp_id", rid, e[16]);
        end
      end
      if (v0 && r0) push(k, {1'b0, 16'(a0 + b0)});
      if (v1 && r1) push(k, {1'b1, 16'(a1 + b1)});
      if (k == 1 && ((v0 && r0) || (v1 && r1))) begin
        g_win.push_back(v1 && r1);
        g_cyc.push_back(cyc);
      end
    end
  endtask

  always @(negedge clk) mon(0, rst_a, ia.req0_valid, ia.req0_ready, ia.req0_a, ia.req0_b,
                            ia.req1_valid, ia.req1_ready, ia.req1_a, ia.req1_b,
                            ia.resp_valid, ia.resp_ready, ia.resp_data, ia.resp_id);
  always @(negedge clk) mon(1, rst_b, ib.req0_valid, ib.req0_ready, ib.req0_a, ib.req0_b,
                            ib.req1_valid, ib.req1_ready, ib.req1_a, ib.req1_b,
                            ib.resp_valid, ib.resp_ready, ib.resp_data, ib.resp_id);
  always @(negedge clk) mon(2, rst_c, ic.req0_valid, ic.req0_ready, ic.req0_a, ic.req0_b,
                            ic.req1_valid, ic.req1_ready, ic.req1_a, ic.req1_b,
                            ic.resp_valid, ic.resp_ready, ic.resp_data, ic.resp_id);

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, got %0d cycles expected fewer", cyc);
    $fatal(1);
  end

  initial begin
    logic exp_w[4];
    logic seen_rv;
    exp_w = '{1'b0, 1'b1, 1'b0, 1'b1};
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    ia.req0_valid = 1'b1; ia.req0_a = 16'h3C00; ia.req0_b = 16'h0400;
    ia.req1_valid = 1'b1; ia.req1_a = 16'h1111; ia.req1_b = 16'h2222;
    ia.resp_ready = 1'b1;
    ib.req0_valid = 1'b0; ib.req0_a = '0; ib.req0_b = '0;
    ib.req1_valid = 1'b0; ib.req1_a = '0; ib.req1_b = '0;
    ib.resp_ready = 1'b1;
    ic.req0_valid = 1'b0; ic.req0_a = '0; ic.req0_b = '0;
    ic.req1_valid = 1'b0; ic.req1_a = '0; ic.req1_b = '0;
    ic.resp_ready = 1'b1;

    // Reset with both valids high, then release: port 0 preferred.
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_rdy0", ia.req0_ready, 0);
    chk("rst_rdy1", ia.req1_ready, 0);
    chk("rst_rv", ia.resp_valid, 0);
    chk("rst_add_a", ia.add_a, 0);
    chk("rst_add_b", ia.add_b, 0);
    chk("rst_busy", ia.busy, 0);
    @(posedge clk); #1; rst_a = 1'b0;
    @(negedge clk);
    chk("rel_rdy0", ia.req0_ready, 1);
    chk("rel_rdy1", ia.req1_ready, 0);

    // Single request LAT=2: accepted at E0, response after E0+2.
    @(posedge clk); #1; ia.req0_valid = 1'b0; ia.req1_valid = 1'b0;
    @(negedge clk);
    chk("t2_add_a", ia.add_a, 16'h3C00);
    chk("t2_add_b", ia.add_b, 16'h0400);
    chk("t2_busy", ia.busy, 1);
    chk("t2_rv_w1", ia.resp_valid, 0);
    @(negedge clk);
    chk("t2_rv_w2", ia.resp_valid, 0);
    @(negedge clk);
    chk("t2_rv", ia.resp_valid, 1);
    chk("t2_data", ia.resp_data, 16'h4000);
    chk("t2_id", ia.resp_id, 0);

    // Backpressure: response stalls, req1 waits, then accepted one cycle after handshake.
    @(posedge clk); #1;
    ia.resp_ready = 1'b0; ia.req0_valid = 1'b1; ia.req0_a = 16'h0011; ia.req0_b = 16'h0022;
    @(negedge clk);
    chk("t4_idle_busy", ia.busy, 0);
    chk("t4_rdy0", ia.req0_ready, 1);
    @(posedge clk); #1;
    ia.req0_valid = 1'b0; ia.req1_valid = 1'b1; ia.req1_a = 16'h0100; ia.req1_b = 16'h0200;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (ia.resp_valid) break;
    end
    chk("t4_rv", ia.resp_valid, 1);
    repeat (5) begin
      chk("t4_hold_data", ia.resp_data, 16'h0033);
      chk("t4_hold_id", ia.resp_id, 0);
      chk("t4_hold_rdy1", ia.req1_ready, 0);
      @(negedge clk);
    end
    @(posedge clk); #1; ia.resp_ready = 1'b1;
    @(negedge clk);
    chk("t4_hs_rdy1", ia.req1_ready, 0);
    chk("t4_hs_rv", ia.resp_valid, 1);
    @(negedge clk);
    chk("t4_next_rdy1", ia.req1_ready, 1);
    chk("t4_next_busy", ia.busy, 0);
    @(posedge clk); #1; ia.req1_valid = 1'b0;
    @(negedge clk);
    chk("t4_acc_busy", ia.busy, 1);
    chk("t4_acc_add_a", ia.add_a, 16'h0100);
    for (int i = 0; i < 10 && (q_a.size() != 0 || ia.busy); i++) @(negedge clk);
    chk("a_drained", q_a.size(), 0);

    // Contention round-robin with LAT=1.
    @(posedge clk); #1;
    rst_b = 1'b0;
    ib.req0_valid = 1'b1; ib.req0_a = 16'h1000; ib.req0_b = 16'h0001;
    ib.req1_valid = 1'b1; ib.req1_a = 16'h2000; ib.req1_b = 16'h0002;
    repeat (12) @(posedge clk);
    #1; ib.req0_valid = 1'b0; ib.req1_valid = 1'b0;
    for (int i = 0; i < 10 && (q_b.size() != 0 || ib.busy); i++) @(negedge clk);
    chk("rr_count", g_win.size(), 4);
    for (int i = 0; i < 4 && i < g_win.size(); i++) begin
      chk("rr_win", g_win[i], exp_w[i]);
      if (i > 0) chk("rr_gap", g_cyc[i] - g_cyc[i-1], 3);
    end
    chk("b_drained", q_b.size(), 0);

    // Operand hold with LAT=15.
    @(posedge clk); #1;
    rst_c = 1'b0; ic.req0_valid = 1'b1; ic.req0_a = 16'h0005; ic.req0_b = 16'h0007;
    @(negedge clk);
    chk("t5_rdy0", ic.req0_ready, 1);
    @(posedge clk); #1;
    ic.req0_valid = 1'b0; ic.req0_a = 16'h7777; ic.req0_b = 16'h1111;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      chk("t5_hold_a", ic.add_a, 16'h0005);
      chk("t5_wait_rv", ic.resp_valid, 0);
    end
    @(negedge clk);
    chk("t5_rv", ic.resp_valid, 1);
    chk("t5_data", ic.resp_data, 16'h000C);

    // Reset in the second WAIT cycle aborts the request and restores ptr.
    @(posedge clk); #1;
    ic.req0_valid = 1'b1; ic.req0_a = 16'h0003; ic.req0_b = 16'h0004;
    @(posedge clk); #1; ic.req0_valid = 1'b0;
    @(posedge clk); #1; rst_c = 1'b1;
    @(posedge clk); #1; rst_c = 1'b0;
    seen_rv = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ic.resp_valid) seen_rv = 1'b1;
    end
    chk("t6_no_resp", seen_rv, 0);
    chk("t6_busy", ic.busy, 0);
    @(posedge clk); #1;
    ic.req0_valid = 1'b1; ic.req1_valid = 1'b1; ic.req1_a = 16'h0009; ic.req1_b = 16'h0001;
    @(negedge clk);
    chk("t6_ptr_rdy0", ic.req0_ready, 1);
    chk("t6_ptr_rdy1", ic.req1_ready, 0);
    @(posedge clk); #1; ic.req0_valid = 1'b0; ic.req1_valid = 1'b0;
    for (int i = 0; i < 25 && (q_c.size() != 0 || ic.busy); i++) @(negedge clk);
    chk("c_drained", q_c.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
